seg7_scan_capture: RTL and testbench
====================================

# seg7_scan_capture

Receive-side counterpart of the hex-to-segment path: observes a multiplexed, active-low 7-segment display bus (digit anodes plus shared segment lines) and recovers the displayed hex nibbles. Requires each pattern to be stable before accepting it, assembles one nibble per digit into a word, and reports a complete frame with a one-cycle valid pulse. Used for display loopback self-test and as a bench monitor behind the display driver.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYCLES, 16, consecutive unchanged samples required before a pattern is accepted (>=1)
- TIMEOUT_CYCLES, 65536, cycles without an accepted capture before a partial frame is discarded (> STABLE_CYCLES)

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  reset; synchronous and active-high
- an_n  in  NUM_DIGITS  digit enables, active-low; bit i selects digit i (digit 0 = least-significant nibble)
- seg_n  in  7  segments, active-low, bit order {g,f,e,d,c,b,a}
- value  out  4*NUM_DIGITS  last complete frame; nibble i = digit i
- err  out  NUM_DIGITS  per digit: pattern in last frame was not a legal hex glyph (nibble reads 0)
- frame_valid  out  1  one-cycle pulse; value/err updated this cycle
- timeout  out  1  one-cycle pulse; partial frame discarded

## Operation
- Legal glyphs (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Every other pattern, including blank 1111111, is illegal and decodes to nibble 0 with err set.
- Stability filter: sample register holds {an_n, seg_n}. If the incoming sample differs from it, stab_cnt clears to 0. Otherwise stab_cnt increments, saturating at STABLE_CYCLES. A capture event fires only on the edge where stab_cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES, so there is at most one capture per stable window.
- Capture with exactly one an_n bit low (digit i): write the decoded nibble to slot i, write err_i, and set seen[i].
- Capture with zero or more than one an_n bit low: ignored; no slot, seen, or timeout-counter change.
- Re-capture of an already-seen digit before the frame completes overwrites that slot (last value wins).
- States:
  - SCAN: collect captures. When seen becomes all ones, go to EMIT.
  - EMIT: one cycle. Copy slots to value and err, pulse frame_valid, clear seen, return to SCAN.
  - A capture arriving in the EMIT cycle belongs to the next frame. Its seen bit is set after the clear.
- Timeout: idle_cnt clears on every accepted capture and increments otherwise.
  - On reaching TIMEOUT_CYCLES with seen nonzero: clear seen, pulse timeout, clear idle_cnt.
  - With seen zero: idle_cnt saturates and no pulse is issued.
  - value and err are not changed by a timeout.
- Reset values: value=0, err=0, frame_valid=0, timeout=0, seen=0, stab_cnt=0, idle_cnt=0, sample register=all ones (blank, no digit), state=SCAN.
- rst mid-frame discards all partial state; the next frame needs fresh captures of every digit.

## Timing
- Inputs are treated as synchronous to clk. A pattern first present at edge k is captured at edge k+STABLE_CYCLES+1.
- frame_valid asserts the edge after the capture that completes seen, giving frame latency = last digit's capture + 1 cycle.
- Outputs are registered; no combinational input-to-output path.
- A glitch of one sample restarts the stability window for that digit.
- Maximum accepted scan rate: each digit must be held ≥ STABLE_CYCLES+1 cycles.

## Structure
- Shared package seg7_pkg:
  - 16 legal glyph constants.
  - SEG_BLANK (7'b1111111).
  - Segment bit-order definition, shared with the display driver.
- Sub-module seg7_to_hex: combinational, input seg_n[6:0], outputs hex[3:0] and illegal. This is the exact inverse of the package table.
- Top level holds the sample register, stab_cnt, idle_cnt, slots, seen, and the two-state FSM.

## Test plan
- NUM_DIGITS=4, STABLE_CYCLES=4: scan digits 0..3 with glyphs 1,2,3,4, 8 cycles each -> one frame_valid, value=16'h4321, err=0.
- Digit 2 shows 1111111 within a legal frame -> frame_valid, nibble 2 = 0, err=4'b0100.
- Digit 1 segments toggle every 3 cycles (never stable 5 samples) -> no capture of digit 1, no frame_valid; after TIMEOUT_CYCLES a single timeout pulse, value unchanged.
- an_n=4'b0011 (two digits low), held 20 cycles -> no capture, seen unchanged.
- rst asserted after 3 of 4 digits captured, then one full scan of F,E,d,C -> exactly one frame_valid, value=16'hCdEF (digit 0=F), no earlier frame.
- Continuous scanning for 3 frames with values changing each frame -> three frame_valid pulses, each one cycle, and each value matches its frame.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: bit order, legal glyphs and the capture FSM state type.
// Active-low segment lines, packed as {g,f,e,d,c,b,a}; no latency, no flow control.
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [SEG_W-1:0] GLYPH_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'b0000011;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'b1000110;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'b0100001;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'b0001110;

  typedef enum logic {
    SCAN = 1'b0,
    EMIT = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Inverse glyph table: active-low segments to hex nibble, illegal patterns read 0.
// Purely combinational; no flow control.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg_n,
  output logic [3:0]       hex,
  output logic             illegal
);

  always_comb begin
    hex     = 4'h0;
    illegal = 1'b0;
    case (seg_n)
      GLYPH_0: hex = 4'h0;
      GLYPH_1: hex = 4'h1;
      GLYPH_2: hex = 4'h2;
      GLYPH_3: hex = 4'h3;
      GLYPH_4: hex = 4'h4;
      GLYPH_5: hex = 4'h5;
      GLYPH_6: hex = 4'h6;
      GLYPH_7: hex = 4'h7;
      GLYPH_8: hex = 4'h8;
      GLYPH_9: hex = 4'h9;
      GLYPH_A: hex = 4'hA;
      GLYPH_B: hex = 4'hB;
      GLYPH_C: hex = 4'hC;
      GLYPH_D: hex = 4'hD;
      GLYPH_E: hex = 4'hE;
      GLYPH_F: hex = 4'hF;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers hex nibbles from a multiplexed active-low 7-seg bus; capture at k+STABLE_CYCLES+1,
// frame_valid one cycle after the completing capture. Observe-only: no backpressure.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [SEG_W-1:0]        seg_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    frame_valid,
  output logic                    timeout
);

  localparam int SMP_W = NUM_DIGITS + SEG_W;
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SMP_W-1:0]                 in_q;
  logic [SMP_W-1:0]                 samp;
  logic [STB_W-1:0]                 stab_cnt;
  logic [IDL_W-1:0]                 idle_cnt;
  logic [NUM_DIGITS-1:0][3:0]       slot;
  logic [NUM_DIGITS-1:0]            slot_err;
  logic [NUM_DIGITS-1:0]            seen;
  logic [NUM_DIGITS-1:0]            sel;
  logic [NUM_DIGITS-1:0]            cap_mask;
  logic [3:0]                       dec_hex;
  logic                             dec_illegal;
  logic                             stable;
  logic                             cap_ok;
  logic                             emit;
  logic                             to_hit;
  scan_state_e                      state, state_nxt;

  // Decode the held sample, not the live bus, so the nibble matches the stable pattern.
  seg7_to_hex u_dec (
    .seg_n   (samp[SEG_W-1:0]),
    .hex     (dec_hex),
    .illegal (dec_illegal)
  );

  assign stable   = (in_q == samp);
  assign sel      = ~samp[SMP_W-1:SEG_W];
  assign cap_ok   = stable && (stab_cnt == STB_W'(STABLE_CYCLES - 1)) && $onehot(sel);
  assign cap_mask = cap_ok ? sel : '0;
  assign to_hit   = !cap_ok && (idle_cnt == IDL_W'(TIMEOUT_CYCLES - 1)) && (seen != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= SCAN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    case (state)
      SCAN: if (&(seen | cap_mask)) state_nxt = EMIT;
      EMIT: begin
        emit      = 1'b1;
        state_nxt = SCAN;
      end
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q        <= '1;
      samp        <= '1;
      stab_cnt    <= '0;
      idle_cnt    <= '0;
      slot        <= '0;
      slot_err    <= '0;
      seen        <= '0;
      value       <= '0;
      err         <= '0;
      frame_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      in_q <= {an_n, seg_n};
      if (!stable) begin
        samp     <= in_q;
        stab_cnt <= '0;
      end else if (stab_cnt != STB_W'(STABLE_CYCLES)) begin
        stab_cnt <= stab_cnt + 1'b1;
      end

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_mask[i]) begin
          slot[i]     <= dec_hex;
          slot_err[i] <= dec_illegal;
        end
      end

      // A capture landing in the EMIT cycle survives the clear and opens the next frame.
      seen <= ((emit || to_hit) ? '0 : seen) | cap_mask;

      if (cap_ok || to_hit)                          idle_cnt <= '0;
      else if (idle_cnt != IDL_W'(TIMEOUT_CYCLES))   idle_cnt <= idle_cnt + 1'b1;

      frame_valid <= emit;
      timeout     <= to_hit;
      if (emit) begin
        value <= slot;
        err   <= slot_err;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with NUM_DIGITS=4, STABLE_CYCLES=4, short timeout.
module tb_seg7_scan_capture;

  localparam int ND  = 4;
  localparam int STB = 4;
  localparam int TO  = 200;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ND-1:0]   an_n = '1;
  logic [6:0]      seg_n = 7'h7F;
  logic [4*ND-1:0] value;
  logic [ND-1:0]   err;
  logic            frame_valid;
  logic            timeout;

  seg7_scan_capture #(
    .NUM_DIGITS     (ND),
    .STABLE_CYCLES  (STB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .value       (value),
    .err         (err),
    .frame_valid (frame_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int fv_cnt = 0;
  int to_cnt = 0;
  int fv_cyc = 0;
  int fv_long = 0;
  logic fv_prev = 1'b0;
  logic [4*ND-1:0] fv_vals[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt++;
      fv_cyc = cyc;
      fv_vals.push_back(value);
      if (fv_prev) fv_long++;
    end
    if (timeout) to_cnt++;
    fv_prev = frame_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] gl(input logic [3:0] n);
    case (n)
      4'h0: gl = 7'b1000000;
      4'h1: gl = 7'b1111001;
      4'h2: gl = 7'b0100100;
      4'h3: gl = 7'b0110000;
      4'h4: gl = 7'b0011001;
      4'h5: gl = 7'b0010010;
      4'h6: gl = 7'b0000010;
      4'h7: gl = 7'b1111000;
      4'h8: gl = 7'b0000000;
      4'h9: gl = 7'b0010000;
      4'hA: gl = 7'b0001000;
      4'hB: gl = 7'b0000011;
      4'hC: gl = 7'b1000110;
      4'hD: gl = 7'b0100001;
      4'hE: gl = 7'b0000110;
      default: gl = 7'b0001110;
    endcase
  endfunction

  // Called on a falling edge; holds digit d with segments s for n cycles.
  task automatic show(input int d, input logic [6:0] s, input int n);
    an_n  = ~(4'b0001 << d);
    seg_n = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic blank(input int n);
    an_n  = '1;
    seg_n = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c0, fv0, to0, q0;
    logic [15:0] fr [3];
    fr[0] = 16'h9A5B;
    fr[1] = 16'h6E07;
    fr[2] = 16'hF8D2;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_value", 32'(value), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_to", 32'(timeout), 32'h0);

    // Basic frame 4321 and frame latency of the last digit
    fv0 = fv_cnt;
    show(0, gl(4'h1), 8);
    show(1, gl(4'h2), 8);
    show(2, gl(4'h3), 8);
    c0 = cyc;
    show(3, gl(4'h4), 8);
    blank(4);
    check("t1_fv_count", 32'(fv_cnt - fv0), 32'd1);
    check("t1_value", 32'(value), 32'h4321);
    check("t1_err", 32'(err), 32'h0);
    check("t1_latency", 32'(fv_cyc - c0), 32'd7);

    // Blank glyph on digit 2
    fv0 = fv_cnt;
    show(0, gl(4'h5), 8);
    show(1, gl(4'h6), 8);
    show(2, 7'b1111111, 8);
    show(3, gl(4'h7), 8);
    blank(4);
    check("t2_fv_count", 32'(fv_cnt - fv0), 32'd1);
    check("t2_value", 32'(value), 32'h7065);
    check("t2_err", 32'(err), 32'h4);

    // Two anodes low must not capture
    fv0 = fv_cnt;
    show(0, gl(4'hA), 8);
    show(1, gl(4'hB), 8);
    an_n  = 4'b0011;
    seg_n = gl(4'h8);
    repeat (20) @(negedge clk);
    check("t3_seen_multi", 32'(dut.seen), 32'h3);
    show(3, gl(4'hE), 8);
    check("t3_no_early_fv", 32'(fv_cnt - fv0), 32'd0);
    show(2, gl(4'hC), 8);
    blank(4);
    check("t3_fv_count", 32'(fv_cnt - fv0), 32'd1);
    check("t3_value", 32'(value), 32'hECBA);

    // Unstable digit 1 -> single timeout, value kept
    fv0 = fv_cnt;
    to0 = to_cnt;
    show(0, gl(4'h3), 8);
    for (int i = 0; i < 80; i++) show(1, (i % 2 == 0) ? gl(4'h1) : gl(4'h7), 3);
    blank(4);
    check("t4_to_count", 32'(to_cnt - to0), 32'd1);
    check("t4_fv_count", 32'(fv_cnt - fv0), 32'd0);
    check("t4_value", 32'(value), 32'hECBA);
    check("t4_seen", 32'(dut.seen), 32'h0);

    // Reset mid-frame discards partial capture
    show(0, gl(4'h7), 8);
    show(1, gl(4'h7), 8);
    show(2, gl(4'h7), 8);
    rst = 1'b1;
    blank(2);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_value", 32'(value), 32'h0);
    fv0 = fv_cnt;
    show(0, gl(4'hF), 8);
    show(1, gl(4'hE), 8);
    show(2, gl(4'hD), 8);
    check("t5_no_early_fv", 32'(fv_cnt - fv0), 32'd0);
    show(3, gl(4'hC), 8);
    blank(4);
    check("t5_fv_count", 32'(fv_cnt - fv0), 32'd1);
    check("t5_value", 32'(value), 32'hCDEF);

    // Three back-to-back frames
    fv0 = fv_cnt;
    q0  = fv_vals.size();
    for (int f = 0; f < 3; f++)
      for (int d = 0; d < 4; d++)
        show(d, gl(fr[f][4*d +: 4]), 6);
    blank(4);
    check("t6_fv_count", 32'(fv_cnt - fv0), 32'd3);
    check("t6_pulse_width", 32'(fv_long), 32'd0);
    for (int f = 0; f < 3; f++) begin
      if (q0 + f < fv_vals.size())
        check($sformatf("t6_frame%0d", f), 32'(fv_vals[q0 + f]), 32'(fr[f]));
      else
        check($sformatf("t6_frame%0d_missing", f), 32'(fv_vals.size()), 32'(q0 + f + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
